ifm_feeder: RTL and testbench



---
 rtl/ifm_feeder.sv | 106 ++++++++++
 tb/tb_ifm_feeder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ifm_feeder.sv
// ifm_feeder: streams a rows x row_len IFM region from 1-cycle-latency memory into the PE with SOR/EOR tags
// Ports: clk, rst_n (async active-low); start/base_addr/row_len/num_rows job request;
//        mem_rd/mem_addr/mem_data memory read port; ready_ifm/w_en_ifm/data_in_ifm PE push
//        ({SOR, EOR, data}); busy while a job runs, done one-cycle completion pulse.
module ifm_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int PAR_WRITE  = 1,
   parameter int ADDR_WIDTH = 8,
   parameter int LEN_WIDTH  = 4
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic [ADDR_WIDTH-1:0]             base_addr,
   input  logic [LEN_WIDTH-1:0]              row_len,
   input  logic [LEN_WIDTH-1:0]              num_rows,
   output logic                              mem_rd,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   input  logic [DATA_WIDTH*PAR_WRITE-1:0]   mem_data,
   input  logic                              ready_ifm,
   output logic                              w_en_ifm,
   output logic [DATA_WIDTH*PAR_WRITE+1:0]   data_in_ifm,
   output logic                              busy,
   output logic                              done
);
   localparam int DW = DATA_WIDTH * PAR_WRITE;
   localparam int CW = 2 * LEN_WIDTH;
   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
   state_t                state_q;
   logic [ADDR_WIDTH-1:0] base_q;
   logic [LEN_WIDTH-1:0]  len_q, col_q, row_q;
   logic [CW-1:0]         total_q, issued_q, xfer_q;
   logic                  rd_q;
   logic [1:0]            tag_q;
   logic [DW+1:0]         h_q, t_q, h_d, t_d, wdata;
   logic [1:0]            cnt_q, cnt_d;
   logic                  run, push, pop, last_col;

   assign run      = state_q == RUN;
   assign push     = rd_q;
   assign pop      = run & (cnt_q != 2'd0) & ready_ifm;
   assign w_en_ifm = pop;
   // a word leaving the FIFO this cycle frees its slot for the read issued now
   assign mem_rd   = run & (issued_q < total_q) &
                     (({1'b0, cnt_q} + {2'b0, rd_q} - {2'b0, pop}) < 3'd2);
   assign mem_addr = base_q + ADDR_WIDTH'(issued_q);
   assign last_col = col_q == len_q - LEN_WIDTH'(1);
   assign wdata    = {tag_q, mem_data};
   assign data_in_ifm = h_q;
   assign busy     = state_q != IDLE;
   assign done     = state_q == FIN;

   // head/tail shift FIFO: the head only changes when a newer word replaces it,
   // so the output keeps the last word once the FIFO drains
   always_comb begin
      h_d   = (pop && cnt_q == 2'd2) ? t_q :
              (push && cnt_q == (pop ? 2'd1 : 2'd0)) ? wdata : h_q;
      t_d   = (push && cnt_q == (pop ? 2'd2 : 2'd1)) ? wdata : t_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         base_q   <= '0;
         len_q    <= '0;
         col_q    <= '0;
         row_q    <= '0;
         total_q  <= '0;
         issued_q <= '0;
         xfer_q   <= '0;
         rd_q     <= 1'b0;
         tag_q    <= '0;
         h_q      <= '0;
         t_q      <= '0;
         cnt_q    <= '0;
      end else begin
         h_q   <= h_d;
         t_q   <= t_d;
         cnt_q <= cnt_d;
         rd_q  <= mem_rd;
         if (mem_rd) begin
            tag_q    <= {col_q == '0, last_col};
            issued_q <= issued_q + CW'(1);
            col_q    <= last_col ? '0 : col_q + LEN_WIDTH'(1);
            if (last_col) row_q <= row_q + LEN_WIDTH'(1);
         end
         if (pop) xfer_q <= xfer_q + CW'(1);
         case (state_q)
            IDLE: if (start) begin
               base_q   <= base_addr;
               len_q    <= row_len;
               total_q  <= CW'(row_len) * CW'(num_rows);
               issued_q <= '0;
               xfer_q   <= '0;
               col_q    <= '0;
               row_q    <= '0;
               state_q  <= (row_len == '0 || num_rows == '0) ? FIN : RUN;
            end
            RUN:  if (pop && xfer_q == total_q - CW'(1)) state_q <= FIN;
            FIN:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ifm_feeder.sv
// tb_ifm_feeder: scoreboard bench for ifm_feeder with a 1-cycle-latency memory model
module tb_ifm_feeder;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, ready_ifm = 1'b1;
   logic [7:0] base_addr = '0, mem_addr, mem_data = '0;
   logic [3:0] row_len = '0, num_rows = '0;
   logic       mem_rd, w_en_ifm, busy, done;
   logic [9:0] data_in_ifm, e;
   logic [7:0] mem [256];
   logic [9:0] exp_q [$];
   int         rd_cyc [$], xf_log [$], dn_log [$];
   logic [7:0] rd_adr [$];
   int         cyc = 0, t0 = 0, mode = 0, rs = -100, n_chk = 0, n_bad = 0;

   ifm_feeder dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .row_len(row_len), .num_rows(num_rows), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .ready_ifm(ready_ifm), .w_en_ifm(w_en_ifm),
      .data_in_ifm(data_in_ifm), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   // ready pattern and optional mid-job start pulse, driven relative to the job start
   always @(posedge clk) begin
      cyc++;
      #2;
      ready_ifm = mode == 0 ? 1'b1 :
                  mode == 1 ? !((cyc - t0) >= 4 && (cyc - t0) <= 7) :
                  1'($urandom_range(0, 1));
      if (cyc - t0 == rs) begin
         start = 1'b1; base_addr = 8'h80; row_len = 4'd2; num_rows = 4'd5;
      end else if (cyc - t0 == rs + 1) start = 1'b0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) if (rst_n) begin
      if (mem_rd) begin
         rd_cyc.push_back(cyc - t0);
         rd_adr.push_back(mem_addr);
      end
      if (w_en_ifm) begin
         xf_log.push_back(cyc - t0);
         check("has_expect", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("word", 32'(data_in_ifm), 32'(e));
         end
      end
      if (done) dn_log.push_back(cyc - t0);
   end

   task automatic begin_job(input logic [7:0] b, input logic [3:0] l, input logic [3:0] n,
                            input int m, input int restart);
      logic [7:0] a;
      @(posedge clk); #1;
      rd_cyc.delete(); rd_adr.delete(); xf_log.delete(); dn_log.delete(); exp_q.delete();
      for (int r = 0; r < int'(n); r++)
         for (int c = 0; c < int'(l); c++) begin
            a = b + 8'(r * int'(l) + c);
            exp_q.push_back({c == 0, c == int'(l) - 1, mem[a]});
         end
      mode = m; rs = restart; t0 = cyc;
      start = 1'b1; base_addr = b; row_len = l; num_rows = n;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic finish_job(input string tag, input int budget);
      for (int i = 0; i < budget && dn_log.size() == 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_done_count"}, 32'(dn_log.size()), 1);
      check({tag, "_all_words"}, 32'(exp_q.size()), 0);
      check({tag, "_busy_low"}, 32'(busy), 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
      repeat (2) @(posedge clk);
      #1;
      check("rst_mem_rd", 32'(mem_rd), 0);
      check("rst_w_en", 32'(w_en_ifm), 0);
      check("rst_data", 32'(data_in_ifm), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      rst_n = 1'b1;

      begin_job(8'h10, 4'd3, 4'd2, 0, -100);
      finish_job("basic", 40);
      check("basic_nrd", 32'(rd_cyc.size()), 6);
      for (int i = 0; i < 6 && i < rd_cyc.size(); i++) begin
         check("basic_rd_cyc", 32'(rd_cyc[i]), 32'(i + 1));
         check("basic_rd_addr", 32'(rd_adr[i]), 32'(8'h10 + i));
      end
      for (int i = 0; i < 6 && i < xf_log.size(); i++) check("basic_xf_cyc", 32'(xf_log[i]), 32'(i + 3));
      if (dn_log.size() > 0) check("basic_done_cyc", 32'(dn_log[0]), 9);

      begin_job(8'h10, 4'd3, 4'd2, 1, -100);
      finish_job("bp", 60);
      check("bp_nrd", 32'(rd_cyc.size()), 6);
      if (rd_cyc.size() > 3) check("bp_rd_resume", 32'(rd_cyc[3]), 8);
      if (xf_log.size() > 1) check("bp_xf_resume", 32'(xf_log[1]), 8);
      if (dn_log.size() > 0) check("bp_done_cyc", 32'(dn_log[0]), 13);

      begin_job(8'h40, 4'd1, 4'd3, 0, -100);
      finish_job("len1", 40);
      check("len1_nxf", 32'(xf_log.size()), 3);

      begin_job(8'h20, 4'd4, 4'd0, 0, -100);
      finish_job("zero", 20);
      check("zero_nrd", 32'(rd_cyc.size()), 0);
      check("zero_nxf", 32'(xf_log.size()), 0);
      if (dn_log.size() > 0) check("zero_done_early", 32'(dn_log[0] >= 1 && dn_log[0] <= 2), 1);

      begin_job(8'hFE, 4'd4, 4'd1, 0, -100);
      finish_job("wrap", 40);
      check("wrap_nrd", 32'(rd_cyc.size()), 4);
      for (int i = 0; i < 4 && i < rd_adr.size(); i++)
         check("wrap_addr", 32'(rd_adr[i]), 32'(8'(8'hFE + i)));

      begin_job(8'h10, 4'd3, 4'd2, 0, 4);
      finish_job("restart", 40);
      check("restart_nxf", 32'(xf_log.size()), 6);
      if (dn_log.size() > 0) check("restart_done_cyc", 32'(dn_log[0]), 9);
      rs = -100;

      begin_job(8'h10, 4'd3, 4'd2, 0, -100);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_mem_rd", 32'(mem_rd), 0);
      check("midrst_w_en", 32'(w_en_ifm), 0);
      check("midrst_data", 32'(data_in_ifm), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_done", 32'(done), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("midrst_no_done", 32'(dn_log.size()), 0);
      check("midrst_idle", 32'(busy), 0);

      begin_job(8'h30, 4'd2, 4'd2, 0, -100);
      finish_job("after_rst", 40);
      check("after_rst_nxf", 32'(xf_log.size()), 4);

      begin_job(8'h05, 4'd15, 4'd15, 2, -100);
      finish_job("rand", 3000);
      check("rand_nxf", 32'(xf_log.size()), 225);
      check("rand_nrd", 32'(rd_cyc.size()), 225);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
